bpm_link_arbiter: RTL and testbench
===================================

BPM_LINK_ARBITER -- requirements
Module: bpm_link_arbiter

Interface
REQ-001 Parameter PACKET_COUNT_WIDTH, default 6: width of the packet budget and packet counter.
REQ-002 Parameter stateDebug, default "false": mark_debug value applied to the arbiter state register.
REQ-003 auroraUserClk  in  1  sole clock, Aurora user clock domain.
REQ-004 auroraResetN  in  1  asynchronous, active-low reset.
REQ-005 auroraFAstrobe  in  1  single-cycle marker for the start of an FA cycle.
REQ-006 auroraChannelUp  in  1  Aurora channel-up status.
REQ-007 maxPackets  in  PACKET_COUNT_WIDTH  packets allowed per FA cycle; 0 = unlimited.
REQ-008 LOCAL_AXI_STREAM_RX_tdata/tvalid/tlast  in  32/1/1  requester 0: locally generated BPM packets.
REQ-009 LOCAL_AXI_STREAM_RX_tready  out  1  requester 0 ready.
REQ-010 PASS_AXI_STREAM_RX_tdata/tvalid/tlast  in  32/1/1  requester 1: forwarded BPM packets.
REQ-011 PASS_AXI_STREAM_RX_tready  out  1  requester 1 ready.
REQ-012 BPM_TX_AXI_STREAM_tdata/tvalid/tlast  out  32/1/1  merged stream to the Aurora TX.
REQ-013 BPM_TX_AXI_STREAM_tready  in  1  Aurora TX ready.
REQ-014 packetCount  out  PACKET_COUNT_WIDTH  packets forwarded in the current FA cycle; saturates at all-ones.
REQ-015 statusStrobe  out  1  one-cycle status pulse.
REQ-016 statusCode  out  2  status code: 0 none, 1 budget exceeded, 2 reserved, 3 reserved.
REQ-017 dbgArbState  out  2  current arbiter state.

Function
REQ-018 States SHALL be IDLE=0, FORWARD=1 and DRAIN=2.
REQ-019 Arbitration SHALL be packet-granular: a grant is held from the first beat until the beat with tlast=1 is accepted.
REQ-020 In IDLE with auroraChannelUp=1, exactly one requester with tvalid=1 SHALL be granted.
REQ-021 In IDLE with both requesters valid, the requester not equal to lastGrant SHALL be granted (round robin).
REQ-022 Grant SHALL be registered, giving a 1-cycle decision latency; no beat is transferred in IDLE.
REQ-023 The grant SHALL go to FORWARD if maxPackets==0 or packetCount<maxPackets, otherwise to DRAIN.
REQ-024 In FORWARD, BPM_TX tdata/tvalid/tlast SHALL combinationally equal the granted input.
REQ-025 In FORWARD, the granted tready SHALL equal BPM_TX tready AND auroraChannelUp; the other requester's tready SHALL be 0.
REQ-026 In FORWARD with auroraChannelUp=0, BPM_TX tvalid SHALL be forced to 0 and the packet held, not aborted.
REQ-027 In DRAIN, the granted tready SHALL be 1, BPM_TX tvalid SHALL be 0, and beats SHALL be discarded.
REQ-028 On acceptance of a tlast beat in FORWARD or DRAIN, the block SHALL update lastGrant and return to IDLE.
REQ-029 packetCount SHALL increment on each tlast beat accepted in FORWARD only.
REQ-030 On auroraFAstrobe, packetCount SHALL clear and the budget-reported flag SHALL clear.
REQ-031 If auroraFAstrobe coincides with a counted tlast, packetCount SHALL become 1.
REQ-032 auroraFAstrobe SHALL NOT abort an in-flight FORWARD or DRAIN packet.
REQ-033 Entry to DRAIN SHALL pulse statusStrobe with statusCode=1 at most once per FA cycle.
REQ-034 statusCode SHALL hold its last value between strobes.
REQ-035 Idle outputs: tvalid=0, tlast=0, tready=0, tdata=0.

Reset
REQ-036 While auroraResetN=0, the block SHALL be in IDLE with lastGrant=1 (requester 0 wins first), packetCount=0, statusStrobe=0, statusCode=0, dbgArbState=0, all tready=0 and BPM_TX tvalid=0.
REQ-037 Reset asserted mid-packet SHALL abandon the packet immediately; no tlast is emitted.
REQ-038 Reset SHALL be released synchronously to auroraUserClk by the surrounding logic.

Structure
REQ-039 State encodings and status codes SHALL live in the shared cell-comm package, alongside the BPM packet length (4 words).
REQ-040 No sub-module is required.
REQ-041 Optionally, one sub-module bpm_link_rr_select SHALL hold the 2-way round-robin choice.

Verification
REQ-042 Only LOCAL sends one 4-word packet, tready=1 -> 4 output beats follow the 1-cycle grant latency; tlast is on beat 4; packetCount=1.
REQ-043 Both requesters continuously valid, maxPackets=0 -> packets alternate LOCAL, PASS, LOCAL...; no beats interleave within a packet.
REQ-044 maxPackets=2, three packets queued -> 2 forwarded; the third is drained with zero output beats; one statusStrobe with code 1; packetCount=2.
REQ-045 auroraChannelUp dropped for 10 cycles mid-packet -> output tvalid=0 and input tready=0 for those cycles; the packet completes intact afterwards.
REQ-046 auroraFAstrobe asserted on the tlast cycle of a forwarded packet -> packetCount=1 on the next cycle and the packet is delivered intact.
REQ-047 auroraResetN asserted during beat 2 of a packet -> next cycle all outputs at reset values and dbgArbState=0.

Source files
------------

// File: rtl/bpm_link_arbiter_pkg.sv
// Shared cell-comm definitions for the BPM link arbiter: arbiter states,
// status codes and BPM packet geometry.
package bpm_link_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_FORWARD = 2'd1,
        ARB_DRAIN   = 2'd2
    } arb_state_t;

    typedef enum logic [1:0] {
        STATUS_NONE            = 2'd0,
        STATUS_BUDGET_EXCEEDED = 2'd1,
        STATUS_RESERVED_2      = 2'd2,
        STATUS_RESERVED_3      = 2'd3
    } status_code_t;

    localparam int unsigned BPM_TDATA_WIDTH  = 32;
    localparam int unsigned BPM_PACKET_WORDS = 4;

    localparam logic GRANT_LOCAL = 1'b0;
    localparam logic GRANT_PASS  = 1'b1;

endpackage

// File: rtl/bpm_link_arbiter_if.sv
// AXI-stream style packet link (data, valid, last, ready) used for both
// arbiter inputs and the merged Aurora TX output.
interface bpm_link_arbiter_if;
    import bpm_link_arbiter_pkg::*;

    logic [BPM_TDATA_WIDTH-1:0] tdata;
    logic                       tvalid;
    logic                       tlast;
    logic                       tready;

    modport master (output tdata, output tvalid, output tlast, input  tready);
    modport slave  (input  tdata, input  tvalid, input  tlast, output tready);

endinterface

// File: rtl/bpm_link_arbiter_rr_select.sv
// Two-way round-robin choice: with both requesters active the one that did
// not win last time is chosen, otherwise whichever is active.
module bpm_link_rr_select (
    input  logic i_req0,
    input  logic i_req1,
    input  logic i_lastGrant,
    output logic o_grant
);

    logic w_both;

    assign w_both  = i_req0 & i_req1;
    assign o_grant = w_both ? ~i_lastGrant : ~i_req0;

endmodule

// File: rtl/bpm_link_arbiter.sv
// Packet-granular arbiter merging local and forwarded BPM packets onto the
// Aurora TX stream, with a per-FA-cycle packet budget and budget status.
module bpm_link_arbiter
    import bpm_link_arbiter_pkg::*;
#(
    parameter int unsigned PACKET_COUNT_WIDTH = 6,
    parameter              stateDebug         = "false"
) (
    input  logic                          auroraUserClk,
    input  logic                          auroraResetN,
    input  logic                          auroraFAstrobe,
    input  logic                          auroraChannelUp,
    input  logic [PACKET_COUNT_WIDTH-1:0] maxPackets,
    bpm_link_arbiter_if.slave             LOCAL_AXI_STREAM_RX,
    bpm_link_arbiter_if.slave             PASS_AXI_STREAM_RX,
    bpm_link_arbiter_if.master            BPM_TX_AXI_STREAM,
    output logic [PACKET_COUNT_WIDTH-1:0] packetCount,
    output logic                          statusStrobe,
    output logic [1:0]                    statusCode,
    output logic [1:0]                    dbgArbState
);

    (* mark_debug = stateDebug *) arb_state_t r_state;

    logic                          r_grant;
    logic                          r_lastGrant;
    logic                          r_budgetReported;
    logic                          r_statusStrobe;
    status_code_t                  r_statusCode;
    logic [PACKET_COUNT_WIDTH-1:0] r_packetCount;

    logic                       w_rrGrant;
    logic                       w_anyValid;
    logic [BPM_TDATA_WIDTH-1:0] w_selData;
    logic                       w_selValid;
    logic                       w_selLast;
    logic                       w_grantedReady;
    logic                       w_acceptLast;
    logic                       w_countedLast;
    logic                       w_withinBudget;

    bpm_link_rr_select u_rr_select (
        .i_req0      (LOCAL_AXI_STREAM_RX.tvalid),
        .i_req1      (PASS_AXI_STREAM_RX.tvalid),
        .i_lastGrant (r_lastGrant),
        .o_grant     (w_rrGrant)
    );

    assign w_anyValid = LOCAL_AXI_STREAM_RX.tvalid | PASS_AXI_STREAM_RX.tvalid;
    assign w_selData  = (r_grant == GRANT_PASS) ? PASS_AXI_STREAM_RX.tdata  : LOCAL_AXI_STREAM_RX.tdata;
    assign w_selValid = (r_grant == GRANT_PASS) ? PASS_AXI_STREAM_RX.tvalid : LOCAL_AXI_STREAM_RX.tvalid;
    assign w_selLast  = (r_grant == GRANT_PASS) ? PASS_AXI_STREAM_RX.tlast  : LOCAL_AXI_STREAM_RX.tlast;

    // A channel drop stalls the packet in place (valid and ready both low)
    // rather than aborting it; DRAIN swallows beats regardless of the link.
    always_comb begin
        BPM_TX_AXI_STREAM.tdata  = '0;
        BPM_TX_AXI_STREAM.tvalid = 1'b0;
        BPM_TX_AXI_STREAM.tlast  = 1'b0;
        w_grantedReady           = 1'b0;
        case (r_state)
            ARB_FORWARD: begin
                BPM_TX_AXI_STREAM.tdata  = w_selData;
                BPM_TX_AXI_STREAM.tvalid = w_selValid & auroraChannelUp;
                BPM_TX_AXI_STREAM.tlast  = w_selLast;
                w_grantedReady           = BPM_TX_AXI_STREAM.tready & auroraChannelUp;
            end
            ARB_DRAIN: w_grantedReady = 1'b1;
            default:   w_grantedReady = 1'b0;
        endcase
        LOCAL_AXI_STREAM_RX.tready = w_grantedReady & (r_grant == GRANT_LOCAL);
        PASS_AXI_STREAM_RX.tready  = w_grantedReady & (r_grant == GRANT_PASS);
    end

    assign w_acceptLast   = w_selValid & w_selLast & w_grantedReady;
    assign w_countedLast  = (r_state == ARB_FORWARD) & w_acceptLast;
    assign w_withinBudget = (maxPackets == '0) || (r_packetCount < maxPackets);

    always_ff @(posedge auroraUserClk or negedge auroraResetN) begin
        if (!auroraResetN) begin
            r_state          <= ARB_IDLE;
            r_grant          <= GRANT_LOCAL;
            r_lastGrant      <= GRANT_PASS;
            r_budgetReported <= 1'b0;
            r_statusStrobe   <= 1'b0;
            r_statusCode     <= STATUS_NONE;
            r_packetCount    <= '0;
        end else begin
            r_statusStrobe <= 1'b0;

            // The FA strobe restarts the count but still credits a packet
            // whose tlast lands on the same cycle.
            if (auroraFAstrobe) begin
                r_packetCount    <= w_countedLast ? PACKET_COUNT_WIDTH'(1) : '0;
                r_budgetReported <= 1'b0;
            end else if (w_countedLast && (r_packetCount != '1)) begin
                r_packetCount <= r_packetCount + PACKET_COUNT_WIDTH'(1);
            end

            case (r_state)
                ARB_IDLE: begin
                    if (auroraChannelUp && w_anyValid) begin
                        r_grant <= w_rrGrant;
                        if (w_withinBudget) begin
                            r_state <= ARB_FORWARD;
                        end else begin
                            r_state <= ARB_DRAIN;
                            if (!r_budgetReported) begin
                                r_statusStrobe   <= 1'b1;
                                r_statusCode     <= STATUS_BUDGET_EXCEEDED;
                                r_budgetReported <= 1'b1;
                            end
                        end
                    end
                end
                ARB_FORWARD, ARB_DRAIN: begin
                    if (w_acceptLast) begin
                        r_lastGrant <= r_grant;
                        r_state     <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    assign packetCount  = r_packetCount;
    assign statusStrobe = r_statusStrobe;
    assign statusCode   = r_statusCode;
    assign dbgArbState  = r_state;

endmodule

// File: tb/tb_bpm_link_arbiter.sv
// Self-checking bench for bpm_link_arbiter: random packets per requester,
// expected merged stream and counters from a packet-level reference model.
module tb_bpm_link_arbiter;
    import bpm_link_arbiter_pkg::*;

    localparam int unsigned PCW = 6;

    logic           clk    = 1'b0;
    logic           rst_n  = 1'b0;
    logic           fa     = 1'b0;
    logic           ch_up  = 1'b1;
    logic [PCW-1:0] max_pk = '0;
    logic [PCW-1:0] pkt_cnt;
    logic           st_strobe;
    logic [1:0]     st_code;
    logic [1:0]     dbg_state;

    bpm_link_arbiter_if loc_if ();
    bpm_link_arbiter_if pass_if ();
    bpm_link_arbiter_if tx_if ();

    bpm_link_arbiter #(
        .PACKET_COUNT_WIDTH (PCW),
        .stateDebug         ("false")
    ) dut (
        .auroraUserClk       (clk),
        .auroraResetN        (rst_n),
        .auroraFAstrobe      (fa),
        .auroraChannelUp     (ch_up),
        .maxPackets          (max_pk),
        .LOCAL_AXI_STREAM_RX (loc_if),
        .PASS_AXI_STREAM_RX  (pass_if),
        .BPM_TX_AXI_STREAM   (tx_if),
        .packetCount         (pkt_cnt),
        .statusStrobe        (st_strobe),
        .statusCode          (st_code),
        .dbgArbState         (dbg_state)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Driver queues ({tlast, tdata} per beat) and observed / expected streams.
    logic [32:0]  q_loc[$];
    logic [32:0]  q_pass[$];
    logic [32:0]  q_got[$];
    logic [32:0]  q_exp[$];
    int unsigned  q_gotcyc[$];

    // Packet-level reference model state.
    logic [127:0] m_loc[$];
    logic [127:0] m_pass[$];
    bit           m_last    = 1'b1;
    int unsigned  m_cnt     = 0;
    bit           m_flag    = 1'b0;
    int unsigned  m_strobes = 0;
    logic [1:0]   m_code    = 2'd0;

    int unsigned  cyc         = 0;
    int unsigned  n_strobe    = 0;
    int unsigned  loc_rise    = 0;
    logic [1:0]   strobe_code = 2'd0;
    bit           loc_prev    = 1'b0;
    bit           tx_random   = 1'b0;

    initial begin
        bit fire;
        loc_if.tvalid = 1'b0; loc_if.tlast = 1'b0; loc_if.tdata = '0;
        forever begin
            @(posedge clk);
            fire = loc_if.tvalid && loc_if.tready;
            #1;
            if (!rst_n) q_loc.delete();
            else if (fire && q_loc.size() > 0) void'(q_loc.pop_front());
            if (q_loc.size() > 0) begin
                loc_if.tvalid = 1'b1;
                {loc_if.tlast, loc_if.tdata} = q_loc[0];
            end else begin
                loc_if.tvalid = 1'b0; loc_if.tlast = 1'b0; loc_if.tdata = '0;
            end
        end
    end

    initial begin
        bit fire;
        pass_if.tvalid = 1'b0; pass_if.tlast = 1'b0; pass_if.tdata = '0;
        forever begin
            @(posedge clk);
            fire = pass_if.tvalid && pass_if.tready;
            #1;
            if (!rst_n) q_pass.delete();
            else if (fire && q_pass.size() > 0) void'(q_pass.pop_front());
            if (q_pass.size() > 0) begin
                pass_if.tvalid = 1'b1;
                {pass_if.tlast, pass_if.tdata} = q_pass[0];
            end else begin
                pass_if.tvalid = 1'b0; pass_if.tlast = 1'b0; pass_if.tdata = '0;
            end
        end
    end

    initial begin
        tx_if.tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            tx_if.tready = tx_random ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshakes and strobes are taken with pre-edge values.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            if (tx_if.tvalid && tx_if.tready) begin
                q_got.push_back({tx_if.tlast, tx_if.tdata});
                q_gotcyc.push_back(cyc);
            end
            if (st_strobe) begin
                n_strobe++;
                strobe_code = st_code;
            end
            if (loc_if.tvalid && !loc_prev) loc_rise = cyc;
            loc_prev = loc_if.tvalid;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

    task automatic push_pkt(input bit src);
        logic [127:0] p;
        logic [32:0]  beat;
        p = {$urandom, $urandom, $urandom, $urandom};
        for (int unsigned i = 0; i < BPM_PACKET_WORDS; i++) begin
            beat = {(i == BPM_PACKET_WORDS - 1), p[32*i +: 32]};
            if (src) q_pass.push_back(beat);
            else     q_loc.push_back(beat);
        end
        if (src) m_pass.push_back(p);
        else     m_loc.push_back(p);
    endtask

    // Resolves every queued packet in arbitration order: alternate while both
    // have work, forward within budget, drop and report once beyond it.
    task automatic run_model();
        bit           pick;
        logic [127:0] p;
        while (m_loc.size() > 0 || m_pass.size() > 0) begin
            if (m_loc.size() > 0 && m_pass.size() > 0) pick = ~m_last;
            else                                       pick = (m_pass.size() > 0);
            m_last = pick;
            p = pick ? m_pass.pop_front() : m_loc.pop_front();
            if (max_pk == 0 || m_cnt < max_pk) begin
                for (int unsigned i = 0; i < BPM_PACKET_WORDS; i++)
                    q_exp.push_back({(i == BPM_PACKET_WORDS - 1), p[32*i +: 32]});
                if (m_cnt < (1 << PCW) - 1) m_cnt++;
            end else if (!m_flag) begin
                m_flag = 1'b1;
                m_strobes++;
                m_code = 2'd1;
            end
        end
    endtask

    task automatic wait_idle(input int unsigned budget, output bit timed_out);
        int unsigned n = 0;
        while ((q_loc.size() > 0 || q_pass.size() > 0 || dbg_state != 2'd0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (n >= budget);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_beats(input int unsigned beats, input int unsigned budget, output bit timed_out);
        int unsigned n = 0;
        while (q_got.size() < beats && n < budget) begin
            @(negedge clk);
            n++;
        end
        timed_out = (q_got.size() < beats);
    endtask

    task automatic fa_pulse();
        @(negedge clk); fa = 1'b1;
        @(negedge clk); fa = 1'b0;
        m_cnt  = 0;
        m_flag = 1'b0;
    endtask

    task automatic clear_streams();
        q_got.delete();
        q_exp.delete();
        q_gotcyc.delete();
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        total++; if (pkt_cnt !== '0)        begin bad++; $display("FAIL rst_count: got %0d expected 0", pkt_cnt); end
        total++; if (st_strobe !== 1'b0)    begin bad++; $display("FAIL rst_strobe: got %b expected 0", st_strobe); end
        total++; if (st_code !== 2'd0)      begin bad++; $display("FAIL rst_code: got %0d expected 0", st_code); end
        total++; if (dbg_state !== 2'd0)    begin bad++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        total++; if ({loc_if.tready, pass_if.tready} !== 2'b00)
            begin bad++; $display("FAIL rst_ready: got %b expected 00", {loc_if.tready, pass_if.tready}); end
        total++; if ({tx_if.tvalid, tx_if.tlast, tx_if.tdata} !== 34'd0)
            begin bad++; $display("FAIL rst_tx: got v=%b l=%b d=%h expected zeros", tx_if.tvalid, tx_if.tlast, tx_if.tdata); end
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++; if (dbg_state !== 2'd0)    begin bad++; $display("FAIL rst_release_state: got %0d expected 0", dbg_state); end
    endtask

    task automatic test_single();
        bit to;
        tx_random = 1'b0; max_pk = '0;
        push_pkt(1'b0);
        run_model();
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL single_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_gotcyc.size() < 4 || q_gotcyc[0] != loc_rise + 1 || q_gotcyc[3] != loc_rise + 4)
            begin bad++; $display("FAIL single_latency: %0d beats, first at %0d, valid at %0d, expected beats at valid+1..valid+4",
                                  q_gotcyc.size(), (q_gotcyc.size() > 0) ? q_gotcyc[0] : 0, loc_rise); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL single_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL single_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL single_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        clear_streams();
    endtask

    task automatic test_round_robin();
        bit to;
        int unsigned nl, np;
        tx_random = 1'b1; max_pk = '0;
        nl = 2 + $urandom_range(0, 2);
        np = 2 + $urandom_range(0, 2);
        for (int unsigned i = 0; i < nl; i++) push_pkt(1'b0);
        for (int unsigned i = 0; i < np; i++) push_pkt(1'b1);
        run_model();
        wait_idle(600, to);
        tx_random = 1'b0;
        total++; if (to) begin bad++; $display("FAIL rr_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL rr_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL rr_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL rr_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        clear_streams();
    endtask

    task automatic test_budget();
        bit to;
        int unsigned s0, ms0;
        fa_pulse();
        max_pk = PCW'(2);
        s0 = n_strobe; ms0 = m_strobes;
        for (int unsigned i = 0; i < 3; i++) push_pkt(1'($urandom_range(0, 1)));
        run_model();
        wait_idle(200, to);
        total++; if (to) begin bad++; $display("FAIL budget_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL budget_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL budget_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        total++; if (n_strobe - s0 != m_strobes - ms0) begin bad++; $display("FAIL budget_strobes: got %0d expected %0d", n_strobe - s0, m_strobes - ms0); end
        total++; if (strobe_code !== m_code) begin bad++; $display("FAIL budget_strobe_code: got %0d expected %0d", strobe_code, m_code); end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL budget_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        clear_streams();

        // Still over budget: dropped silently, no second report.
        s0 = n_strobe; ms0 = m_strobes;
        push_pkt(1'($urandom_range(0, 1)));
        run_model();
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL budget2_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL budget2_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        total++; if (n_strobe - s0 != m_strobes - ms0) begin bad++; $display("FAIL budget2_strobes: got %0d expected %0d", n_strobe - s0, m_strobes - ms0); end
        total++; if (st_code !== m_code) begin bad++; $display("FAIL budget2_code_hold: got %0d expected %0d", st_code, m_code); end
        clear_streams();

        // A new FA cycle restores the budget.
        fa_pulse();
        push_pkt(1'($urandom_range(0, 1)));
        run_model();
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL budget3_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL budget3_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL budget3_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL budget3_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        total++; if (st_code !== m_code) begin bad++; $display("FAIL budget3_code_hold: got %0d expected %0d", st_code, m_code); end
        clear_streams();
        max_pk = '0;
    endtask

    task automatic test_channel_down();
        bit to;
        tx_random = 1'b0; max_pk = '0;
        push_pkt(1'b1);
        run_model();
        wait_beats(2, 50, to);
        total++; if (to) begin bad++; $display("FAIL chdown_wait: got %0d beats expected 2", q_got.size()); end
        ch_up = 1'b0;
        for (int unsigned i = 0; i < 10; i++) begin
            if (i > 0) @(negedge clk);
            #1;
            total++; if ({tx_if.tvalid, pass_if.tready} !== 2'b00)
                begin bad++; $display("FAIL chdown_stall%0d: got tvalid,tready=%b expected 00", i, {tx_if.tvalid, pass_if.tready}); end
        end
        @(negedge clk);
        total++; if (q_got.size() != 2) begin bad++; $display("FAIL chdown_held: got %0d beats expected 2", q_got.size()); end
        ch_up = 1'b1;
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL chdown_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL chdown_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL chdown_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        clear_streams();
    endtask

    task automatic test_fa_on_tlast();
        bit to;
        tx_random = 1'b0; max_pk = '0;
        push_pkt(1'b0);
        // The strobe lands on this packet's tlast, so the FA cycle opens with it counted.
        m_cnt = 0; m_flag = 1'b0;
        run_model();
        wait_beats(3, 50, to);
        total++; if (to) begin bad++; $display("FAIL fa_wait: got %0d beats expected 3", q_got.size()); end
        fa = 1'b1;
        @(negedge clk);
        fa = 1'b0;
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL fa_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        wait_idle(50, to);
        total++; if (to) begin bad++; $display("FAIL fa_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL fa_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL fa_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        clear_streams();
    endtask

    task automatic test_saturate();
        bit to;
        tx_random = 1'b0; max_pk = '0;
        fa_pulse();
        for (int unsigned i = 0; i < 66; i++) push_pkt(1'($urandom_range(0, 1)));
        run_model();
        wait_idle(2000, to);
        total++; if (to) begin bad++; $display("FAIL sat_timeout: still busy, state=%0d", dbg_state); end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL sat_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL sat_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL sat_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        clear_streams();
    endtask

    task automatic test_reset_mid();
        bit to;
        tx_random = 1'b0; max_pk = '0;
        push_pkt(1'b0);
        run_model();
        wait_beats(1, 50, to);
        total++; if (to) begin bad++; $display("FAIL rmid_wait: got %0d beats expected 1", q_got.size()); end
        rst_n = 1'b0;
        // Only the beat already accepted ever leaves; the model restarts from reset.
        while (q_exp.size() > 1) void'(q_exp.pop_back());
        m_last = 1'b1; m_cnt = 0; m_flag = 1'b0; m_code = 2'd0;
        @(negedge clk);
        total++; if (dbg_state !== 2'd0) begin bad++; $display("FAIL rmid_state: got %0d expected 0", dbg_state); end
        total++; if (pkt_cnt !== '0)     begin bad++; $display("FAIL rmid_count: got %0d expected 0", pkt_cnt); end
        total++; if ({st_strobe, st_code} !== 3'b000) begin bad++; $display("FAIL rmid_status: got %b expected 000", {st_strobe, st_code}); end
        total++; if ({loc_if.tready, pass_if.tready} !== 2'b00)
            begin bad++; $display("FAIL rmid_ready: got %b expected 00", {loc_if.tready, pass_if.tready}); end
        total++; if ({tx_if.tvalid, tx_if.tlast, tx_if.tdata} !== 34'd0)
            begin bad++; $display("FAIL rmid_tx: got v=%b l=%b d=%h expected zeros", tx_if.tvalid, tx_if.tlast, tx_if.tdata); end
        @(negedge clk); rst_n = 1'b1;
        repeat (5) @(negedge clk);
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL rmid_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL rmid_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        clear_streams();

        // After reset LOCAL wins the first contested decision.
        push_pkt(1'b1);
        push_pkt(1'b0);
        run_model();
        wait_idle(100, to);
        total++; if (to) begin bad++; $display("FAIL rpost_timeout: still busy, state=%0d", dbg_state); end
        total++; if (q_got.size() != q_exp.size()) begin bad++; $display("FAIL rpost_len: got %0d beats expected %0d", q_got.size(), q_exp.size()); end
        for (int unsigned i = 0; i < q_exp.size() && i < q_got.size(); i++) begin
            total++; if (q_got[i] !== q_exp[i]) begin bad++; $display("FAIL rpost_beat%0d: got %h expected %h", i, q_got[i], q_exp[i]); end
        end
        total++; if (pkt_cnt !== m_cnt[PCW-1:0]) begin bad++; $display("FAIL rpost_count: got %0d expected %0d", pkt_cnt, m_cnt); end
        clear_streams();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_budget();
        test_channel_down();
        test_fa_on_tlast();
        test_saturate();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
